// File: rtl/lc330_mc_control.sv
// Multi-cycle control FSM for the LC330 shared-ALU/shared-memory datapath.
// Optional performance counters are built when LC330_PERFCNT_EN is defined.
module lc330_mc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  opcode,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        aluout_we,
    output logic        mem_addr_src,
    output logic        mem_re,
    output logic        mem_we,
    output logic        rf_we,
    output logic        rf_dst_sel,
    output logic [1:0]  rf_wd_src,
    output logic        alu_a_src,
    output logic [1:0]  alu_b_src,
    output logic        alu_op,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StMemAddr,
        StLwRead,
        StLwWb,
        StSwWrite,
        StBeq,
        StJalr,
        StHalt
    } stateT;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpNand = 3'b001;
    localparam logic [2:0] OpLw   = 3'b010;
    localparam logic [2:0] OpSw   = 3'b011;
    localparam logic [2:0] OpBeq  = 3'b100;
    localparam logic [2:0] OpJalr = 3'b101;
    localparam logic [2:0] OpHalt = 3'b110;

    stateT stateQ, stateD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        aluout_we    = 1'b0;
        mem_addr_src = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        rf_wd_src    = 2'd0;
        alu_a_src    = 1'b0;
        alu_b_src    = 2'd0;
        alu_op       = 1'b0;
        halted       = 1'b0;

        unique case (stateQ)
            StFetch: begin
                mem_re    = 1'b1;
                alu_b_src = 2'd1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    stateD = StDecode;
                end
            end
            StDecode: begin
                // Speculative branch target PC+1+offset, parked in ALUOut.
                alu_b_src = 2'd2;
                aluout_we = 1'b1;
                case (opcode)
                    OpAdd, OpNand: stateD = StExecR;
                    OpLw, OpSw:    stateD = StMemAddr;
                    OpBeq:         stateD = StBeq;
                    OpJalr:        stateD = StJalr;
                    OpHalt:        stateD = StHalt;
                    default:       stateD = StFetch;
                endcase
            end
            StExecR: begin
                alu_a_src = 1'b1;
                alu_op    = opcode[0];
                aluout_we = 1'b1;
                stateD    = StWbR;
            end
            StWbR: begin
                rf_we  = 1'b1;
                stateD = StFetch;
            end
            StMemAddr: begin
                alu_a_src = 1'b1;
                alu_b_src = 2'd2;
                aluout_we = 1'b1;
                stateD    = (opcode == OpLw) ? StLwRead : StSwWrite;
            end
            StLwRead: begin
                mem_re       = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) begin
                    mdr_we = 1'b1;
                    stateD = StLwWb;
                end
            end
            StLwWb: begin
                rf_we      = 1'b1;
                rf_dst_sel = 1'b1;
                rf_wd_src  = 2'd1;
                stateD     = StFetch;
            end
            StSwWrite: begin
                mem_we       = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) begin
                    stateD = StFetch;
                end
            end
            StBeq: begin
                alu_a_src = 1'b1;
                pc_src    = 2'd1;
                pc_we     = eq;
                stateD    = StFetch;
            end
            StJalr: begin
                // Regfile reads before it writes, so the jump uses the old regA.
                rf_we      = 1'b1;
                rf_dst_sel = 1'b1;
                rf_wd_src  = 2'd2;
                pc_we      = 1'b1;
                pc_src     = 2'd2;
                stateD     = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: stateD = StFetch;
        endcase
    end

`ifdef LC330_PERFCNT_EN
    logic [31:0] cycleCountQ, instrCountQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCountQ <= 32'd0;
            instrCountQ <= 32'd0;
        end else begin
            if (stateQ != StHalt) begin
                cycleCountQ <= cycleCountQ + 32'd1;
            end
            if (stateQ == StDecode) begin
                instrCountQ <= instrCountQ + 32'd1;
            end
        end
    end

    assign cycle_count = cycleCountQ;
    assign instr_count = instrCountQ;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_lc330_mc_control.sv
// Scoreboard bench for lc330_mc_control: expected control vectors are queued
// per cycle as stimulus is driven, then popped and compared at the falling edge.
module tb_lc330_mc_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic        eq = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, mdr_we, aluout_we, mem_addr_src, mem_re, mem_we;
    logic        rf_we, rf_dst_sel, alu_a_src, alu_op, halted;
    logic [1:0]  pc_src, rf_wd_src, alu_b_src;
    logic [31:0] cycle_count, instr_count;

    lc330_mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mdr_we(mdr_we),
        .aluout_we(aluout_we), .mem_addr_src(mem_addr_src), .mem_re(mem_re),
        .mem_we(mem_we), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .rf_wd_src(rf_wd_src),
        .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef enum int {F, D, XR, WR, MA, LR, LB, SW, BQ, JR, HT} bst;

    logic [17:0] got;
    assign got = {pc_we, pc_src, ir_we, mdr_we, aluout_we, mem_addr_src, mem_re, mem_we,
                  rf_we, rf_dst_sel, rf_wd_src, alu_a_src, alu_b_src, alu_op, halted};

    logic [17:0] sbq[$];
    string       tagq[$];
    int          total = 0;
    int          bad = 0;
    int          expCycles = 0;
    int          expInstrs = 0;

    function automatic logic [17:0] model(input bst s, input logic [2:0] op, input logic e,
                                          input logic r);
        logic       pw = 0, iw = 0, mw = 0, aw = 0, mas = 0, re = 0, we = 0, rw = 0;
        logic       dst = 0, aa = 0, ao = 0, h = 0;
        logic [1:0] ps = 0, wd = 0, bb = 0;
        case (s)
            F:  begin re = 1; bb = 1; iw = r; pw = r; end
            D:  begin bb = 2; aw = 1; end
            XR: begin aa = 1; ao = op[0]; aw = 1; end
            WR: begin rw = 1; end
            MA: begin aa = 1; bb = 2; aw = 1; end
            LR: begin re = 1; mas = 1; mw = r; end
            LB: begin rw = 1; dst = 1; wd = 1; end
            SW: begin we = 1; mas = 1; end
            BQ: begin aa = 1; ps = 1; pw = e; end
            JR: begin rw = 1; dst = 1; wd = 2; pw = 1; ps = 2; end
            HT: begin h = 1; end
            default: ;
        endcase
        return {pw, ps, iw, mw, aw, mas, re, we, rw, dst, wd, aa, bb, ao, h};
    endfunction

    // Drives one cycle's inputs, queues the expected outputs, stops at the falling edge.
    task automatic drive(input bst s, input logic [2:0] op, input logic e, input logic r,
                         input string tag);
        opcode = op;
        eq = e;
        mem_ready = r;
        sbq.push_back(model(s, op, e, r));
        tagq.push_back(tag);
        if (s != HT) expCycles++;
        if (s == D) expInstrs++;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expCycles = 0;
        expInstrs = 0;
    endtask

    // Runs a full instruction given its state list and inputs per cycle.
    task automatic run_seq(input bst sts[$], input logic [2:0] op, input logic e,
                           input logic rdy[$], input string name);
        logic [17:0] exp;
        string       tag;
        for (int i = 0; i < sts.size(); i++) begin
            drive(sts[i], op, e, rdy[i], $sformatf("%s_c%0d", name, i + 1));
            exp = sbq.pop_front();
            tag = tagq.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", tag, got, exp);
            end
            finish_cycle();
        end
    endtask

    task automatic test_reset();
        logic [17:0] exp;
        string       tag;
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = 3'd0;
        #2;
        sbq.push_back(model(F, 3'd0, 1'b0, 1'b0));
        tagq.push_back("reset_outputs");
        @(negedge clk);
        exp = sbq.pop_front();
        tag = tagq.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
        total++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: got=%0d/%0d expected=0/0", cycle_count, instr_count);
        end
        finish_cycle();
        rst = 1'b0;
        expCycles = 0;
        expInstrs = 0;
    endtask

    task automatic test_rtype();
        run_seq('{F, D, XR, WR}, 3'b000, 1'b0, '{1, 1, 1, 1}, "add");
        run_seq('{F, D, XR, WR}, 3'b001, 1'b0, '{1, 1, 1, 1}, "nand");
    endtask

    task automatic test_lw_stall();
        run_seq('{F, D, MA, LR, LR, LR, LR, LB}, 3'b010, 1'b0, '{1, 1, 1, 0, 0, 0, 1, 1},
                "lw_stall");
    endtask

    task automatic test_sw_fetch_stall();
        run_seq('{F, F, D, MA, SW, SW}, 3'b011, 1'b0, '{0, 1, 1, 1, 0, 1}, "sw_stall");
    endtask

    task automatic test_beq();
        run_seq('{F, D, BQ}, 3'b100, 1'b1, '{1, 1, 1}, "beq_taken");
        run_seq('{F, D, BQ}, 3'b100, 1'b0, '{1, 1, 1}, "beq_not");
    endtask

    task automatic test_jalr_noop();
        run_seq('{F, D, JR}, 3'b101, 1'b0, '{1, 1, 1}, "jalr");
        run_seq('{F, D}, 3'b111, 1'b0, '{1, 1}, "noop");
    endtask

    task automatic test_halt();
        bst   sts[$];
        logic rdy[$];
        logic [17:0] exp;
        string tag;
        sts = '{F, D};
        rdy = '{1, 1};
        for (int i = 0; i < 20; i++) begin
            sts.push_back(HT);
            rdy.push_back(i[0]);
        end
        run_seq(sts, 3'b110, 1'b0, rdy, "halt");
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        sbq.push_back(model(F, 3'b110, 1'b0, 1'b0));
        tagq.push_back("halt_rst");
        #1;
        exp = sbq.pop_front();
        tag = tagq.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
        finish_cycle();
        rst = 1'b0;
        expCycles = 0;
        expInstrs = 0;
    endtask

    task automatic test_rst_in_sw();
        logic [17:0] exp;
        string tag;
        run_seq('{F, D, MA, SW, SW}, 3'b011, 1'b0, '{1, 1, 1, 0, 0}, "sw_pre_rst");
        drive(SW, 3'b011, 1'b0, 1'b0, "sw_stalled");
        exp = sbq.pop_front();
        tag = tagq.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
        #2;
        rst = 1'b1;
        sbq.push_back(model(F, 3'b011, 1'b0, 1'b0));
        tagq.push_back("sw_async_rst");
        #1;
        exp = sbq.pop_front();
        tag = tagq.pop_front();
        total++;
        if (got !== exp || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
        finish_cycle();
        rst = 1'b0;
        expCycles = 0;
        expInstrs = 0;
    endtask

    task automatic test_perf();
        logic [31:0] wantC, wantI;
        do_reset();
        run_seq('{F, D, XR, WR}, 3'b000, 1'b0, '{1, 1, 1, 1}, "p_add");
        run_seq('{F, D, MA, LR, LR, LB}, 3'b010, 1'b0, '{1, 1, 1, 0, 1, 1}, "p_lw");
        run_seq('{F, D, MA, SW}, 3'b011, 1'b0, '{1, 1, 1, 1}, "p_sw");
        run_seq('{F, D, BQ}, 3'b100, 1'b1, '{1, 1, 1}, "p_beq");
        run_seq('{F, D, JR}, 3'b101, 1'b0, '{1, 1, 1}, "p_jalr");
        run_seq('{F, D}, 3'b111, 1'b0, '{1, 1}, "p_noop");
        run_seq('{F, D, XR, WR}, 3'b001, 1'b0, '{1, 1, 1, 1}, "p_nand");
        run_seq('{F, F, D, BQ}, 3'b100, 1'b0, '{0, 1, 1, 1}, "p_beq2");
        run_seq('{F, D}, 3'b111, 1'b0, '{1, 1}, "p_noop2");
        run_seq('{F, D, HT, HT, HT, HT}, 3'b110, 1'b0, '{1, 1, 1, 1, 1, 1}, "p_halt");
`ifdef LC330_PERFCNT_EN
        wantC = 32'(expCycles);
        wantI = 32'(expInstrs);
`else
        wantC = 32'd0;
        wantI = 32'd0;
`endif
        total++;
        if (instr_count !== wantI) begin
            bad++;
            $display("FAIL instr_count: got=%0d expected=%0d", instr_count, wantI);
        end
        total++;
        if (cycle_count !== wantC) begin
            bad++;
            $display("FAIL cycle_count: got=%0d expected=%0d", cycle_count, wantC);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_fetch_stall();
        test_beq();
        test_jalr_noop();
        test_halt();
        test_rst_in_sw();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
